// File: rtl/obstacle_gen.sv
// obstacle_gen: ten-slot obstacle spawner/scroller driven by a frame-tick prescaler.
// Define OBSTACLE_GEN_SPEEDUP_EN to add a speed register that rises every 8 spawns.
module obstacle_gen #(
    parameter int unsigned TICK_DIV  = 1666667,
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned OBS_W     = 40,
    parameter int unsigned GAP_TICKS = 90,
    parameter int unsigned MIN_H     = 40,
    parameter int unsigned SPEED     = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   gamemode,
    output logic [199:0] obstacle_x,
    output logic [179:0] obstacle_y,
    output logic [9:0]   active_mask,
    output logic         tick
);
    localparam int unsigned NSLOT = 10;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);
    localparam logic [15:0]   SEED       = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
    localparam logic [9:0]    SPAWN_XL   = 10'(SCREEN_W);
    localparam logic [9:0]    SPAWN_XR   = 10'(SCREEN_W + OBS_W);
    localparam logic [9:0]    SCR_H      = 10'(SCREEN_H);
    localparam logic [9:0]    MINH       = 10'(MIN_H);

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_END   = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(gamemode);

    logic [15:0]    lfsr_q, lfsr_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           tick_q, tick_d;
    logic [199:0]   x_q, x_d;
    logic [179:0]   y_q, y_d;
    logic [9:0]     mask_q, mask_d;

    logic           fire, spawned, found;
    logic [3:0]     sel;
    logic [9:0]     spd, xr, xl, h, raw, y_top, y_bot;

`ifdef OBSTACLE_GEN_SPEEDUP_EN
    localparam logic [3:0] SPEED4 = 4'(SPEED);
    logic [3:0] speed_q, speed_d;
    logic [2:0] tally_q, tally_d;
    assign spd = {6'b0, speed_q};
`else
    assign spd = 10'(SPEED);
`endif

    // Geometry for a spawn this cycle; all y math stays 10 bits so raw+h cannot wrap.
    always_comb begin
        h     = MINH + {3'b0, lfsr_q[6:0]};
        raw   = {1'b0, lfsr_q[15:7]};
        y_top = ((raw + h) <= SCR_H) ? raw : (SCR_H - h);
        y_bot = y_top + h;
    end

    // Lowest slot free before this tick; scanning downward lets the lowest index win.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = NSLOT; i > 0; i--) begin
            if (!mask_q[i-1]) begin
                sel   = 4'(i - 1);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        presc_d = presc_q;
        gap_d   = gap_q;
        tick_d  = tick_q;
        x_d     = x_q;
        y_d     = y_q;
        mask_d  = mask_q;
        fire    = 1'b0;
        spawned = 1'b0;
        xr      = '0;
        xl      = '0;

        case (mode)
            MODE_INIT: begin
                presc_d = '0;
                gap_d   = '0;
                tick_d  = 1'b0;
                x_d     = '0;
                y_d     = '0;
                mask_d  = '0;
            end
            MODE_RUN: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    fire    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                tick_d = (presc_d == PRESC_LAST);
            end
            default: ;
        endcase

        if (fire) begin
            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (mask_q[i]) begin
                    xr = x_q[20*i +: 10];
                    xl = x_q[20*i+10 +: 10];
                    if (xr <= spd) begin
                        x_d[20*i +: 20] = '0;
                        y_d[18*i +: 18] = '0;
                        mask_d[i]       = 1'b0;
                    end else begin
                        x_d[20*i +: 10]    = xr - spd;
                        x_d[20*i+10 +: 10] = (xl > spd) ? (xl - spd) : '0;
                    end
                end
            end
            if (gap_q == GAP_LAST) begin
                gap_d   = '0;
                spawned = found;
                for (int unsigned i = 0; i < NSLOT; i++) begin
                    if (found && sel == 4'(i)) begin
                        x_d[20*i +: 20] = {SPAWN_XL, SPAWN_XR};
                        y_d[18*i +: 18] = {y_top[8:0], y_bot[8:0]};
                        mask_d[i]       = 1'b1;
                    end
                end
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

`ifdef OBSTACLE_GEN_SPEEDUP_EN
    always_comb begin
        speed_d = speed_q;
        tally_d = tally_q;
        if (mode == MODE_INIT) begin
            speed_d = SPEED4;
            tally_d = '0;
        end else if (spawned) begin
            tally_d = tally_q + 1'b1;
            if (tally_q == 3'd7 && speed_q < 4'd8) begin
                speed_d = speed_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            speed_q <= SPEED4;
            tally_q <= '0;
        end else begin
            speed_q <= speed_d;
            tally_q <= tally_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q  <= SEED;
            presc_q <= '0;
            gap_q   <= '0;
            tick_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            mask_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            presc_q <= presc_d;
            gap_q   <= gap_d;
            tick_q  <= tick_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mask_q  <= mask_d;
        end
    end

    assign obstacle_x  = x_q;
    assign obstacle_y  = y_q;
    assign active_mask = mask_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Directed bench for obstacle_gen with TICK_DIV=4, GAP_TICKS=3; a background
// monitor checks every scroll step against the expected per-tick speed.
module tb_obstacle_gen;
    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   gamemode;
    logic [199:0] obstacle_x;
    logic [179:0] obstacle_y;
    logic [9:0]   active_mask;
    logic         tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    obstacle_gen #(
        .TICK_DIV (4),
        .GAP_TICKS(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gamemode   (gamemode),
        .obstacle_x (obstacle_x),
        .obstacle_y (obstacle_y),
        .active_mask(active_mask),
        .tick       (tick)
    );

    task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] lfsr_m;
    always @(posedge clk) begin
        if (rst) lfsr_m <= 16'hACE1;
        else     lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [17:0] exp_y(input logic [15:0] l);
        int h, raw, top;
        h   = 40 + int'(l[6:0]);
        raw = int'(l[15:7]);
        top = (raw + h <= 480) ? raw : 480 - h;
        return {9'(top), 9'(top + h)};
    endfunction

    function automatic logic [19:0] xf(input int age);
        return {10'(640 - 2*age), 10'(680 - 2*age)};
    endfunction

    // Scroll monitor: snapshot while tick is high, compare after the edge that consumes it.
    logic [199:0] snap_x;
    logic [9:0]   snap_m;
    logic         snap_v = 1'b0;
    int           spawns_m = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (rst === 1'b1 || gamemode == 2'b00) begin
            spawns_m = 0;
            snap_v   = 1'b0;
        end else begin
            if (snap_v && gamemode == 2'b01) begin
                int spd;
`ifdef OBSTACLE_GEN_SPEEDUP_EN
                spd = (2 + spawns_m / 8 > 8) ? 8 : 2 + spawns_m / 8;
`else
                spd = 2;
`endif
                for (int i = 0; i < 10; i++) begin
                    if (snap_m[i]) begin
                        int xr, xl;
                        logic [20:0] e;
                        xr = int'(snap_x[20*i +: 10]);
                        xl = int'(snap_x[20*i+10 +: 10]);
                        if (xr <= spd) e = '0;
                        else e = {1'b1, 10'((xl > spd) ? xl - spd : 0), 10'(xr - spd)};
                        check("scroll", {active_mask[i], obstacle_x[20*i +: 20]}, e);
                    end
                end
                spawns_m += $countones(active_mask & ~snap_m);
            end
            snap_v = (tick === 1'b1);
            snap_x = obstacle_x;
            snap_m = active_mask;
        end
    end

    // Waits for tick (bounded), captures the LFSR a spawn would use, then moves past the tick edge.
    task automatic do_tick(output int n, output logic [15:0] l);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (tick === 1'b1) break;
        end
        if (tick !== 1'b1) check("tick_timeout", 200'(tick), 200'd1);
        l = lfsr_m;
        @(negedge clk);
    endtask

    int           n;
    logic [15:0]  l, l33;
    logic [199:0] ex;
    logic [199:0] pre_x;
    logic [9:0]   pre_m;
    logic [17:0]  ys;
    int           st, guard;
    logic         found;

    initial begin
        rst      = 1'b1;
        gamemode = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_x", obstacle_x, '0);
        check("rst_y", 200'(obstacle_y), '0);
        check("rst_mask", 200'(active_mask), '0);
        check("rst_tick", 200'(tick), '0);
        rst      = 1'b0;
        gamemode = 2'b01;

        do_tick(n, l);
        check("first_tick_cycle", 200'(n), 200'd3);

`ifdef OBSTACLE_GEN_SPEEDUP_EN
        for (int t = 2; t <= 25; t++) do_tick(n, l);
        check("speed3_slot0", 200'(obstacle_x[19:0]), 200'({10'd595, 10'd635}));
        guard = 0;
        while (spawns_m < 56 && guard < 3000) begin
            do_tick(n, l);
            guard++;
        end
        check("reach_56_spawns", 200'(spawns_m >= 56), 200'd1);
        do_tick(n, l);
        pre_x = obstacle_x;
        pre_m = active_mask;
        do_tick(n, l);
        found = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (!found && pre_m[j] && active_mask[j] && pre_x[20*j +: 10] > 10'd8) begin
                found = 1'b1;
                check("speed_sat", 200'(pre_x[20*j +: 10] - obstacle_x[20*j +: 10]), 200'd8);
            end
        end
        check("sat_slot_found", 200'(found), 200'd1);
`else
        check("t1_mask", 200'(active_mask), '0);
        do_tick(n, l);
        check("tick_period", 200'(n), 200'd3);
        check("t2_mask", 200'(active_mask), '0);
        do_tick(n, l);
        check("t3_mask", 200'(active_mask), 200'd1);
        check("t3_x0", 200'(obstacle_x[19:0]), 200'({10'd640, 10'd680}));
        check("t3_y0", 200'(obstacle_y[17:0]), 200'(exp_y(l)));
        ys = obstacle_y[17:0];
        check("t3_h_range", 200'((ys[8:0] - ys[17:9]) >= 9'd40 && (ys[8:0] - ys[17:9]) <= 9'd167), 200'd1);
        check("t3_ybot_bound", 200'(ys[8:0] <= 9'd480), 200'd1);
        do_tick(n, l);
        check("t4_x0", 200'(obstacle_x[19:0]), 200'({10'd638, 10'd678}));
        check("t4_mask", 200'(active_mask), 200'd1);
        do_tick(n, l);
        check("t5_x0", 200'(obstacle_x[19:0]), 200'({10'd636, 10'd676}));

        ex = '0;
        ex[19:0] = {10'd636, 10'd2};
        force dut.x_q = ex;
        @(negedge clk);
        release dut.x_q;
        check("forced_x0", 200'(obstacle_x[19:0]), 200'({10'd636, 10'd2}));
        do_tick(n, l);
        check("t6_mask", 200'(active_mask), 200'b10);
        check("t6_x0_zero", 200'(obstacle_x[19:0]), '0);
        check("t6_y0_zero", 200'(obstacle_y[17:0]), '0);
        check("t6_x1", 200'(obstacle_x[39:20]), 200'({10'd640, 10'd680}));
        check("t6_y1", 200'(obstacle_y[35:18]), 200'(exp_y(l)));

        l33 = '0;
        for (int t = 7; t <= 36; t++) begin
            do_tick(n, l);
            if (t == 33) l33 = l;
        end
        ex = '0;
        for (int k = 0; k < 10; k++) begin
            st = (k == 0) ? 9 : (k == 1) ? 6 : 3*k + 6;
            ex[20*k +: 20] = xf(36 - st);
        end
        check("full_mask", 200'(active_mask), 200'h3FF);
        check("full_x", obstacle_x, ex);
        check("full_y9", 200'(obstacle_y[179:162]), 200'(exp_y(l33)));

        @(negedge clk);
        gamemode = 2'b10;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("pause_tick", 200'(tick), '0);
            if (i % 25 == 24) check("pause_x", obstacle_x, ex);
        end
        check("pause_mask", 200'(active_mask), 200'h3FF);
        gamemode = 2'b01;
        do_tick(n, l);
        check("resume_phase", 200'(n), 200'd2);
        for (int k = 0; k < 10; k++) begin
            st = (k == 0) ? 9 : (k == 1) ? 6 : 3*k + 6;
            ex[20*k +: 20] = xf(37 - st);
        end
        check("t37_x", obstacle_x, ex);

        gamemode = 2'b11;
        repeat (3) @(negedge clk);
        check("end_hold_x", obstacle_x, ex);
        gamemode = 2'b00;
        @(negedge clk);
        check("clr_x", obstacle_x, '0);
        check("clr_y", 200'(obstacle_y), '0);
        check("clr_mask", 200'(active_mask), '0);
        check("clr_tick", 200'(tick), '0);
        gamemode = 2'b01;
        do_tick(n, l);
        check("clr_first_tick", 200'(n), 200'd3);
        check("clr_t1_mask", 200'(active_mask), '0);
        do_tick(n, l);
        check("clr_t2_mask", 200'(active_mask), '0);
        do_tick(n, l);
        check("clr_t3_mask", 200'(active_mask), 200'd1);
        check("clr_t3_x0", 200'(obstacle_x[19:0]), 200'({10'd640, 10'd680}));
        check("clr_t3_y0", 200'(obstacle_y[17:0]), 200'(exp_y(l)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_gen.md
# obstacle_gen

Obstacle source for the runner game. Keeps ten obstacle slots, spawns new obstacles at the right screen edge with LFSR-derived vertical position and height, and scrolls them left on a frame tick. It drives the packed `obstacle_x`/`obstacle_y` buses that the player/collision logic consumes, and it follows that logic's `gamemode`.

## Interface

**Parameters**
- `TICK_DIV`, 1666667: clocks per scroll tick (60 Hz at 100 MHz).
- `SCREEN_W`, 640: spawn x position.
- `SCREEN_H`, 480: bottom bound for obstacle y.
- `OBS_W`, 40: obstacle width in pixels.
- `GAP_TICKS`, 90: ticks between spawn attempts.
- `MIN_H`, 40: minimum obstacle height. Heights span `MIN_H` to `MIN_H`+127.
- `SPEED`, 2: pixels moved per tick.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. A seed of 0 is replaced by 1.

**Ports**
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. Synchronous, active-high.
- `gamemode`, input, 2: 00 initial, 01 in-game, 10 paused, 11 ended.
- `obstacle_x`, output, 200: slot i at [20i+19:20i] = {x_left[9:0], x_right[9:0]}.
- `obstacle_y`, output, 180: slot i at [18i+17:18i] = {y_top[8:0], y_bot[8:0]}.
- `active_mask`, output, 10: bit i is high when slot i holds an obstacle.
- `tick`, output, 1: one-cycle pulse on every scroll tick.

## Operation

**Slots**
- An inactive slot drives all-zero x and y fields.
- Renderers clip x values beyond `SCREEN_W`.

**LFSR**
- 16-bit Galois, polynomial mask 16'hB400.
- Advances every clock in every mode. It is not cleared by mode 00.

**Prescaler**
- Counts 0..`TICK_DIV`-1, only in mode 01.
- `tick` is high on the cycle the count equals `TICK_DIV`-1; the count then wraps to 0.

**Action on each tick**
- Scroll: for each active slot:
  - If `x_right` <= speed, the slot is freed (fields zeroed, mask bit cleared).
  - Otherwise `x_right` -= speed, and `x_left` = `x_left` - speed, saturating at 0.
- Spawn counter: increments on each tick. When it reaches `GAP_TICKS`-1 it wraps to 0 and a spawn is attempted.
- Spawn, into the lowest-index slot that was free before this tick:
  - `x_left` = `SCREEN_W`, `x_right` = `SCREEN_W`+`OBS_W`.
  - h = `MIN_H` + lfsr[6:0].
  - raw = lfsr[15:7].
  - `y_top` = raw if raw+h <= `SCREEN_H`, else `SCREEN_H`-h.
  - `y_bot` = `y_top`+h.
  - The new obstacle is not scrolled on its spawn tick.
- If no slot was free, the spawn is dropped and the counter still wraps.
- Slots freed on a tick become available from the next tick onward.

**Modes**
- 00: every cycle, clears all slots, the prescaler and the spawn counter.
- 10 or 11: holds all state, including the prescaler phase.
- Leaving 10 resumes from the held phase.

**Width rules**
- y arithmetic uses 10 bits before truncation, so that raw+h never wraps.

## Timing

- Reset: `obstacle_x`=0, `obstacle_y`=0, `active_mask`=0, `tick`=0; prescaler=0; spawn counter=0; LFSR=seed.
- `rst` overrides `gamemode` and takes effect mid-tick.
- All outputs are registered. Slot updates from a tick are visible on the cycle after `tick` is high (latency 1).
- Mode 00 clears take effect on the next edge.
- A mode change on the same edge as a tick: the mode sampled on that edge decides the outcome. The tick proceeds only if that mode is 01.
- There is no handshake. Consumers sample the buses at any time, and the buses change only on the cycle following `tick` or a mode-00 clear.

## Configuration

**`OBSTACLE_GEN_SPEEDUP_EN`**
- Defined:
  - A speed register resets, and is cleared by mode 00, to `SPEED`.
  - It increments by 1 after every 8 successful spawns, saturating at 8.
  - The scroll uses the speed register value.
- Undefined:
  - The speed is the constant `SPEED`.
  - No speed register or spawn tally is built.

## Test plan

Bench parameters: `TICK_DIV`=4, `GAP_TICKS`=3, defaults otherwise, macro undefined unless noted.

- Reset: `rst` high for 2 clocks with any `gamemode` -> all outputs 0. After release in mode 01, `tick` first pulses on the 4th clock.
- Spawn and scroll: mode 01 from reset -> third tick spawns slot 0 at x={640,680} with 40 <= h <= 167 and `y_bot` <= 480; next tick gives x={638,678}; `active_mask`=10'b1.
- Exit and free-slot rule:
  - Force slot 0 to `x_right`=2 -> slot 0 zeroed one cycle after the next tick.
  - A spawn attempt on that same tick goes to slot 1, not slot 0.
- Full and held modes:
  - All 10 slots active plus a spawn attempt -> buses unchanged apart from the scroll; the spawn counter wraps.
  - Mode 10 for 100 clocks -> buses, `tick` and prescaler phase frozen; returning to 01 resumes the phase.
- Clear: switch 11 -> 00 -> all outputs 0 on the next edge. Returning to 01 -> first spawn after 3 ticks.
- `OBSTACLE_GEN_SPEEDUP_EN` defined -> after 8 spawns the step becomes 3 px/tick; speed saturates at 8 after 48 spawns.
